midi_uart_rx: RTL and testbench

- Receives serial MIDI on one input pin and decodes channel voice messages into the note, velocity and gate controls that drive a single voice.
- Sits between the board MIDI input (after the opto-isolator) and the voice: `note` feeds `midi_data`, `gate` feeds `enable`, and `velocity` may feed `amplitude`.
- Contains a UART deserializer (8N1, LSB first) followed by a MIDI message parser with running status.

---
 rtl/midi_uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_midi_uart_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// MIDI input receiver: 8N1 UART deserializer followed by a channel-voice message
// parser with running status, producing note/velocity/gate for a single voice.
module midi_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 384,
    parameter int unsigned CHANNEL      = 0,
    parameter bit          OMNI         = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] note,
    output logic [7:0] velocity,
    output logic       gate,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_error
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] CHAN = 4'(CHANNEL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    uart_state_t      state, state_d;
    logic             rx_meta, rxs;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic             byte_valid_d, framing_error_d;
    logic [7:0]       byte_data_d;

    logic [7:0] rs, rs_d;
    logic       rs_valid, rs_valid_d;
    logic       idx, idx_d;
    logic [6:0] d1, d1_d;
    logic [7:0] note_d, velocity_d;
    logic       gate_d;
    logic       one_byte, chan_match, msg_done;

    // UART: next-state and datapath
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        bit_idx_d       = bit_idx;
        shift_d         = shift;
        byte_valid_d    = 1'b0;
        byte_data_d     = byte_data;
        framing_error_d = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift;
                        state_d      = ST_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Parser: running status, data-byte collection and voice actions
    always_comb begin
        rs_d       = rs;
        rs_valid_d = rs_valid;
        idx_d      = idx;
        d1_d       = d1;
        note_d     = note;
        velocity_d = velocity;
        gate_d     = gate;
        msg_done   = 1'b0;
        one_byte   = (rs[7:5] == 3'b110);
        chan_match = OMNI || (rs[3:0] == CHAN);
        if (byte_valid) begin
            if (byte_data[7:3] == 5'b11111) begin
                rs_d = rs;
            end else if (byte_data[7:4] == 4'hF) begin
                rs_valid_d = 1'b0;
                idx_d      = 1'b0;
            end else if (byte_data[7]) begin
                rs_d       = byte_data;
                rs_valid_d = 1'b1;
                idx_d      = 1'b0;
            end else if (rs_valid && !one_byte) begin
                if (!idx) begin
                    d1_d  = byte_data[6:0];
                    idx_d = 1'b1;
                end else begin
                    idx_d    = 1'b0;
                    msg_done = 1'b1;
                end
            end
        end
        // byte_data holds d2 when a two-byte message completes
        if (msg_done && chan_match) begin
            unique case (rs[7:4])
                4'h9: begin
                    if (byte_data != 8'h00) begin
                        note_d     = {1'b0, d1};
                        velocity_d = byte_data;
                        gate_d     = 1'b1;
                    end else if (d1 == note[6:0]) begin
                        gate_d = 1'b0;
                    end
                end
                4'h8: begin
                    if (d1 == note[6:0]) gate_d = 1'b0;
                end
                4'hB: begin
                    if (d1 == 7'h7B || d1 == 7'h78) gate_d = 1'b0;
                end
                default: gate_d = gate;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rxs           <= 1'b1;
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            framing_error <= 1'b0;
            rs            <= '0;
            rs_valid      <= 1'b0;
            idx           <= 1'b0;
            d1            <= '0;
            note          <= '0;
            velocity      <= '0;
            gate          <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rxs           <= rx_meta;
            state         <= state_d;
            cnt           <= cnt_d;
            bit_idx       <= bit_idx_d;
            shift         <= shift_d;
            byte_valid    <= byte_valid_d;
            byte_data     <= byte_data_d;
            framing_error <= framing_error_d;
            rs            <= rs_d;
            rs_valid      <= rs_valid_d;
            idx           <= idx_d;
            d1            <= d1_d;
            note          <= note_d;
            velocity      <= velocity_d;
            gate          <= gate_d;
        end
    end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: serial byte driver, message-level model of the voice
// outputs, per-cycle compare process and a few literal timing/value pins.
module tb_midi_uart_rx;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] note, velocity, byte_data;
    logic       gate, byte_valid, framing_error;
    logic [7:0] note_o, velocity_o, byte_data_o;
    logic       gate_o, byte_valid_o, framing_error_o;

    midi_uart_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(0), .OMNI(1'b0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .note(note), .velocity(velocity), .gate(gate),
        .byte_valid(byte_valid), .byte_data(byte_data), .framing_error(framing_error)
    );

    midi_uart_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(0), .OMNI(1'b1)) dut_o (
        .clk(clk), .rst(rst), .rx(rx), .note(note_o), .velocity(velocity_o), .gate(gate_o),
        .byte_valid(byte_valid_o), .byte_data(byte_data_o), .framing_error(framing_error_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_bv_cyc = 0;
    int note_chg_cyc = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] prev_note = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] popped;

    // model state, index 0 = channel 0 only, index 1 = omni
    logic [7:0] m_note[2];
    logic [7:0] m_vel[2];
    logic       m_gate[2];
    logic [7:0] m_st[2];
    bit         m_has[2];
    int         m_n[2];
    logic [7:0] m_buf[2][2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_note[k] = 8'h00; m_vel[k] = 8'h00; m_gate[k] = 1'b0;
            m_st[k] = 8'h00; m_has[k] = 1'b0; m_n[k] = 0;
        end
    endtask

    task automatic model_byte(input int k, input logic [7:0] b);
        logic [7:0] d1, d2;
        int need;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_has[k] = 1'b0; m_n[k] = 0; return; end
        if (b >= 8'h80) begin m_st[k] = b; m_has[k] = 1'b1; m_n[k] = 0; return; end
        if (!m_has[k]) return;
        need = (m_st[k] >= 8'hC0 && m_st[k] <= 8'hDF) ? 1 : 2;
        m_buf[k][m_n[k]] = b;
        m_n[k]++;
        if (m_n[k] < need) return;
        m_n[k] = 0;
        if (k == 0 && m_st[k][3:0] != 4'h0) return;
        if (need == 1) return;
        d1 = m_buf[k][0];
        d2 = m_buf[k][1];
        case (m_st[k][7:4])
            4'h9: begin
                if (d2 != 8'h00) begin
                    m_note[k] = d1; m_vel[k] = d2; m_gate[k] = 1'b1;
                end else if (d1 == m_note[k]) begin
                    m_gate[k] = 1'b0;
                end
            end
            4'h8: if (d1 == m_note[k]) m_gate[k] = 1'b0;
            4'hB: if (d1 == 8'h7B || d1 == 8'h78) m_gate[k] = 1'b0;
            default: ;
        endcase
    endtask

    // per-cycle compare of outputs against the model, then advance model on each received byte
    always @(negedge clk) begin
        if (!rst) begin
            chk("note", note, m_note[0]);
            chk("velocity", velocity, m_vel[0]);
            chk("gate", 8'(gate), 8'(m_gate[0]));
            chk("omni_note", note_o, m_note[1]);
            chk("omni_velocity", velocity_o, m_vel[1]);
            chk("omni_gate", 8'(gate_o), 8'(m_gate[1]));
            if (note != prev_note) note_chg_cyc = cyc;
            prev_note = note;
            if (framing_error) fe_cnt++;
            if (byte_valid) begin
                bv_cnt++;
                last_bv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bv_unexpected: got byte_valid data=%02h expected no strobe", byte_data);
                end else begin
                    popped = exp_q.pop_front();
                    chk("byte_data", byte_data, popped);
                    model_byte(0, popped);
                    model_byte(1, popped);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        if (stop_ok) exp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start_cyc = cyc;
            rx = fr[i];
            repeat (CPB - 1) @(posedge clk);
        end
        if (stop_ok) begin
            repeat (2) @(posedge clk);
            #1;
            chk("bv_seen_qsize", 8'(exp_q.size()), 8'd0);
            exp_q.delete();
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv_before;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_note", note, 8'h00);
        chk("rst_velocity", velocity, 8'h00);
        chk("rst_gate", 8'(gate), 8'h00);
        chk("rst_byte_valid", 8'(byte_valid), 8'h00);
        chk("rst_byte_data", byte_data, 8'h00);
        chk("rst_framing_error", 8'(framing_error), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // note-on, with timing pins on first strobe and output update
        send_byte(8'h90, 1'b1);
        chk("first_bv_latency", 8'(last_bv_cyc - start_cyc), 8'd79);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        chk("note_update_latency", 8'(note_chg_cyc - start_cyc), 8'd80);
        chk("lit_note_3c", note, 8'h3C);
        chk("lit_vel_64", velocity, 8'h64);
        chk("lit_gate_on", 8'(gate), 8'h01);
        chk("lit_byte_data_hold", byte_data, 8'h64);

        // running status note-on, off for other note, running note-off
        send_byte(8'h40, 1'b1);
        send_byte(8'h50, 1'b1);
        chk("lit_rs_note_40", note, 8'h40);
        chk("lit_rs_vel_50", velocity, 8'h50);
        send3(8'h80, 8'h3C, 8'h00);
        chk("lit_off_other_gate", 8'(gate), 8'h01);
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("lit_rs_off_gate", 8'(gate), 8'h00);
        chk("lit_rs_off_note_held", note, 8'h40);

        // realtime byte mid-message, other channel, omni instance
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h64, 1'b1);
        chk("lit_rt_gate", 8'(gate), 8'h01);
        chk("lit_rt_note", note, 8'h3C);
        send3(8'h91, 8'h45, 8'h7F);
        chk("lit_ch1_note_unchanged", note, 8'h3C);
        chk("lit_omni_note_45", note_o, 8'h45);
        chk("lit_omni_vel_7f", velocity_o, 8'h7F);

        // all notes off, then sysex clears running status
        send3(8'hB0, 8'h7B, 8'h00);
        chk("lit_all_off_gate", 8'(gate), 8'h00);
        send3(8'hF0, 8'h3C, 8'h64);
        chk("lit_sysex_gate", 8'(gate), 8'h00);
        chk("lit_sysex_vel", velocity, 8'h64);

        // framing error, line held in break
        bv_before = bv_cnt;
        send_byte(8'h90, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("fe_count", 8'(fe_cnt), 8'd1);
        chk("fe_no_strobe", 8'(bv_cnt - bv_before), 8'd0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        send3(8'h90, 8'h30, 8'h10);
        chk("lit_after_fe_note", note, 8'h30);
        chk("lit_after_fe_gate", 8'(gate), 8'h01);
        chk("fe_count_final", 8'(fe_cnt), 8'd1);

        // single-cycle glitch on idle line
        bv_before = bv_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_no_strobe", 8'(bv_cnt - bv_before), 8'd0);
        chk("glitch_no_fe", 8'(fe_cnt), 8'd1);

        // reset in the middle of a byte
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        chk("midrst_note", note, 8'h00);
        chk("midrst_velocity", velocity, 8'h00);
        chk("midrst_gate", 8'(gate), 8'h00);
        chk("midrst_byte_data", byte_data, 8'h00);
        chk("midrst_byte_valid", 8'(byte_valid), 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        prev_note = 8'h00;
        repeat (4) @(posedge clk);
        send3(8'h90, 8'h3C, 8'h64);
        chk("lit_post_rst_note", note, 8'h3C);
        chk("lit_post_rst_vel", velocity, 8'h64);
        chk("lit_post_rst_gate", 8'(gate), 8'h01);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
